// File: rtl/dino_pkg.sv
// ----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dino-obstacle game control logic.
//   spawn_state_t   : obstacle spawner FSM states
//   obstacle_t      : obstacle kind encodings carried on obstacle_type
//   LFSR_MASK       : Galois feedback mask for the 8-bit obstacle LFSR
//   GAP_W / OBS_W   : widths of the gap code and the obstacle type
//   lfsr_advance()  : one step of the right-shifting Galois LFSR
//   gap_select()    : maps two random bits to a gap code, with the hard-mode
//                     restriction to the two shortest gaps
// ----------------------------------------------------------------------------
package dino_pkg;

   localparam int GAP_W = 2;
   localparam int OBS_W = 2;

   localparam logic [7:0] LFSR_MASK = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SPAWN  = 3'd4
   } spawn_state_t;

   typedef enum logic [OBS_W-1:0] {
      OBS_CACTUS_SMALL = 2'd0,
      OBS_CACTUS_LARGE = 2'd1,
      OBS_BIRD_LOW     = 2'd2,
      OBS_BIRD_HIGH    = 2'd3
   } obstacle_t;

   // Right shift; the bit falling off the bottom decides whether the
   // feedback mask is folded back in.
   function automatic logic [7:0] lfsr_advance(input logic [7:0] value);
      logic [7:0] shifted;
      shifted = value >> 1;
      if (value[0]) begin
         return shifted ^ LFSR_MASK;
      end
      return shifted;
   endfunction

   // In hard mode the upper gap bit is cleared so only the two shortest
   // gaps can be chosen.
   function automatic logic [GAP_W-1:0] gap_select(input logic [1:0] bits,
                                                   input logic       hard);
      if (hard) begin
         return {1'b0, bits[0]};
      end
      return bits;
   endfunction

endpackage

// File: rtl/lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8
// 8-bit right-shifting Galois LFSR used as the obstacle randomness source.
// Only the low nibble leaves the block: bits [1:0] pick the gap, bits [3:2]
// pick the obstacle kind.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, reloads SEED
//   step     : advance the sequence by one on this edge
//   low_bits : current LFSR bits [3:0]
// Parameters:
//   SEED     : reset value, must be nonzero or the sequence locks at zero
// ----------------------------------------------------------------------------
module lfsr8
   import dino_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       step,
   output logic [3:0] low_bits
);

   logic [7:0] lfsr_state;

   // The sequence only moves when the spawner commits a load, so the
   // same value is offered again after an aborted arm.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_state <= SEED;
      end else if (step) begin
         lfsr_state <= lfsr_advance(lfsr_state);
      end
   end

   assign low_bits = lfsr_state[3:0];

endmodule

// File: rtl/obstacle_spawner.sv
// ----------------------------------------------------------------------------
// obstacle_spawner
// Control side of the obstacle down-counter. Loads the counter with a
// pseudo-random gap code, waits for it to reach zero, emits a one-cycle
// spawn pulse with a pseudo-random obstacle kind, then re-arms. Once the
// spawn total reaches the hard difficulty level only short gaps are used.
// Ports:
//   clock         : rising-edge clock
//   reset         : synchronous active-high reset
//   enable        : game running; low parks the block in IDLE
//   count_in      : current down-counter value
//   load_en       : one-cycle load strobe to the down-counter
//   load_value    : gap code presented with load_en (0 otherwise)
//   spawn         : one-cycle obstacle-appears pulse
//   obstacle_type : kind of the latest obstacle, held until the next spawn
//   spawn_count   : spawns since reset, saturating at 255
// Parameters:
//   COUNT_W       : width of count_in
//   LFSR_SEED     : LFSR reset value (nonzero)
//   HARD_LEVEL    : spawn_count[7:6] level at which short gaps are forced
// ----------------------------------------------------------------------------
module obstacle_spawner
   import dino_pkg::*;
#(
   parameter int         COUNT_W    = 9,
   parameter logic [7:0] LFSR_SEED  = 8'hA5,
   parameter logic [1:0] HARD_LEVEL = 2'd2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [COUNT_W-1:0] count_in,
   output logic               load_en,
   output logic [GAP_W-1:0]   load_value,
   output logic               spawn,
   output logic [OBS_W-1:0]   obstacle_type,
   output logic [7:0]         spawn_count
);

   spawn_state_t state_q;
   spawn_state_t state_d;

   logic [3:0]       rand_bits;
   logic             do_load;
   logic             do_spawn;
   logic             hard_mode;
   logic [GAP_W-1:0] next_gap;

   lfsr8 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .step    (do_load),
      .low_bits(rand_bits)
   );

   // Each state's action is committed on the edge that leaves it, and only
   // if enable is still high then; that is what makes a drop in ARM or
   // SPAWN a clean abort with nothing advanced.
   assign do_load   = enable && (state_q == ST_ARM);
   assign do_spawn  = enable && (state_q == ST_SPAWN);
   assign hard_mode = (spawn_count[7:6] >= HARD_LEVEL);
   assign next_gap  = gap_select(rand_bits[1:0], hard_mode);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. SETTLE deliberately ignores count_in so the counter
   // has a cycle to absorb the load before a stale zero can be seen.
   // Dropping enable always parks in IDLE, and re-enable resumes through
   // ARM so a fresh gap is loaded.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_ARM;
         end
         ST_ARM: begin
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (count_in == '0) begin
               state_d = ST_SPAWN;
            end
         end
         ST_SPAWN: begin
            state_d = ST_ARM;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!enable) begin
         state_d = ST_IDLE;
      end
   end

   // Registered outputs. The strobes are high for exactly the cycle after
   // the committing edge; obstacle_type and spawn_count change on the same
   // edge that raises spawn and hold otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_en       <= 1'b0;
         load_value    <= '0;
         spawn         <= 1'b0;
         obstacle_type <= '0;
         spawn_count   <= '0;
      end else begin
         load_en    <= do_load;
         load_value <= do_load ? next_gap : '0;
         spawn      <= do_spawn;
         if (do_spawn) begin
            obstacle_type <= rand_bits[3:2];
            if (spawn_count != 8'hFF) begin
               spawn_count <= spawn_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_obstacle_spawner.sv
// ----------------------------------------------------------------------------
// tb_obstacle_spawner
// Self-checking bench for obstacle_spawner. A timeline model tracks, in
// edge numbers, when the next load, the first zero check and the next
// spawn are due, and predicts the strobes, gap codes, obstacle kinds and
// the spawn total from the game rules.
// ----------------------------------------------------------------------------
module tb_obstacle_spawner;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [8:0] count_in;
   logic       load_en;
   logic [1:0] load_value;
   logic       spawn;
   logic [1:0] obstacle_type;
   logic [7:0] spawn_count;

   int checks = 0;
   int passes = 0;

   // Timeline model state
   int         t_edge     = 0;
   bit         parked     = 1'b1;
   int         load_due   = -1;
   int         check_from = -1;
   int         spawn_due  = -1;
   logic [7:0] m_lfsr     = 8'hA5;
   int         m_count    = 0;
   int         m_total    = 0;
   logic [1:0] m_type     = 2'b00;
   logic       m_load_en  = 1'b0;
   logic [1:0] m_load_val = 2'b00;
   logic       m_spawn    = 1'b0;

   obstacle_spawner #(
      .COUNT_W   (9),
      .LFSR_SEED (8'hA5),
      .HARD_LEVEL(2'd2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .count_in     (count_in),
      .load_en      (load_en),
      .load_value   (load_value),
      .spawn        (spawn),
      .obstacle_type(obstacle_type),
      .spawn_count  (spawn_count)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic [7:0] s;
      s = v >> 1;
      return v[0] ? (s ^ 8'hB8) : s;
   endfunction

   // Spawn totals of 128 or more put spawn_count[7:6] at level 2 or above.
   function automatic logic [1:0] exp_gap(input logic [7:0] l, input int n);
      logic [1:0] g;
      g = l[1:0];
      if (n >= 128) g[1] = 1'b0;
      return g;
   endfunction

   // Advance the model by one clock edge given the inputs sampled there.
   task automatic model_edge(input logic en, input logic [8:0] cnt, input logic rst);
      t_edge++;
      m_load_en  = 1'b0;
      m_load_val = 2'b00;
      m_spawn    = 1'b0;
      if (rst) begin
         parked = 1'b1; load_due = -1; check_from = -1; spawn_due = -1;
         m_lfsr = 8'hA5; m_count = 0; m_total = 0; m_type = 2'b00;
      end else if (!en) begin
         parked = 1'b1; load_due = -1; check_from = -1; spawn_due = -1;
      end else if (parked) begin
         parked   = 1'b0;
         load_due = t_edge + 1;
      end else if (load_due == t_edge) begin
         m_load_en  = 1'b1;
         m_load_val = exp_gap(m_lfsr, m_count);
         m_lfsr     = lfsr_next(m_lfsr);
         load_due   = -1;
         check_from = t_edge + 2;
      end else if (spawn_due == t_edge) begin
         m_spawn   = 1'b1;
         m_type    = m_lfsr[3:2];
         m_total++;
         m_count   = (m_count < 255) ? m_count + 1 : 255;
         spawn_due = -1;
         load_due  = t_edge + 1;
      end else if (check_from >= 0 && t_edge >= check_from && cnt == 9'd0) begin
         check_from = -1;
         spawn_due  = t_edge + 1;
      end
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
   task automatic tick(input logic en, input logic [8:0] cnt, input logic rst);
      @(negedge clock);
      enable   = en;
      count_in = cnt;
      reset    = rst;
      @(posedge clock);
      model_edge(en, cnt, rst);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 9'd5, 1'b1);
         checks++;
         if ({load_en, load_value, spawn, obstacle_type, spawn_count} !== 14'd0)
            $display("[TB] FAIL reset_outputs got le=%b lv=%b sp=%b ty=%b cnt=%0d want all 0",
                     load_en, load_value, spawn, obstacle_type, spawn_count);
         else passes++;
      end
      tick(1'b1, 9'd5, 1'b0);
      checks++;
      if (load_en !== 1'b0) $display("[TB] FAIL reset_early_load got %b want 0", load_en);
      else passes++;
      tick(1'b1, 9'd5, 1'b0);
      checks++;
      if (load_en !== 1'b1 || load_value !== 2'b01)
         $display("[TB] FAIL reset_first_load got le=%b lv=%b want le=1 lv=01", load_en, load_value);
      else passes++;
   endtask

   task automatic test_spawn_cycle;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 9'd5, 1'b0);
         checks++;
         if (spawn !== 1'b0 || load_en !== 1'b0)
            $display("[TB] FAIL spawn_nonzero_quiet got sp=%b le=%b want 0 0", spawn, load_en);
         else passes++;
      end
      tick(1'b1, 9'd0, 1'b0);
      checks++;
      if (spawn !== 1'b0) $display("[TB] FAIL spawn_too_early got %b want 0", spawn);
      else passes++;
      tick(1'b1, 9'd5, 1'b0);
      checks++;
      if (spawn !== 1'b1 || obstacle_type !== 2'b10 || spawn_count !== 8'd1)
         $display("[TB] FAIL spawn_first got sp=%b ty=%b cnt=%0d want sp=1 ty=10 cnt=1",
                  spawn, obstacle_type, spawn_count);
      else passes++;
      tick(1'b1, 9'd5, 1'b0);
      checks++;
      if (spawn !== 1'b0 || load_en !== 1'b1 || load_value !== 2'b10)
         $display("[TB] FAIL spawn_reload got sp=%b le=%b lv=%b want sp=0 le=1 lv=10",
                  spawn, load_en, load_value);
      else passes++;
   endtask

   task automatic test_settle_guard;
      int last_load  = 0;
      int last_spawn = -1;
      int n_spawn    = 0;
      for (int i = 1; i <= 24; i++) begin
         tick(1'b1, 9'd0, 1'b0);
         checks++;
         if (load_en !== m_load_en || spawn !== m_spawn)
            $display("[TB] FAIL settle_strobes i=%0d got le=%b sp=%b want le=%b sp=%b",
                     i, load_en, spawn, m_load_en, m_spawn);
         else passes++;
         if (load_en === 1'b1) last_load = i;
         if (spawn === 1'b1) begin
            n_spawn++;
            checks++;
            if (i - last_load !== 3)
               $display("[TB] FAIL settle_load_to_spawn got %0d want 3", i - last_load);
            else passes++;
            if (last_spawn >= 0) begin
               checks++;
               if (i - last_spawn !== 4)
                  $display("[TB] FAIL settle_period got %0d want 4", i - last_spawn);
               else passes++;
            end
            last_spawn = i;
         end
      end
      checks++;
      if (n_spawn !== 6) $display("[TB] FAIL settle_spawn_total got %0d want 6", n_spawn);
      else passes++;
   endtask

   task automatic test_enable_drop;
      logic [1:0] want_gap;
      int         guard;
      // Drop during ARM: re-enable, then drop exactly on the committing edge.
      tick(1'b0, 9'd7, 1'b0);
      want_gap = exp_gap(m_lfsr, m_count);
      tick(1'b1, 9'd7, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 9'd7, 1'b0);
         checks++;
         if (load_en !== 1'b0 || spawn !== 1'b0)
            $display("[TB] FAIL drop_arm_quiet got le=%b sp=%b want 0 0", load_en, spawn);
         else passes++;
      end
      tick(1'b1, 9'd7, 1'b0);
      tick(1'b1, 9'd7, 1'b0);
      checks++;
      if (load_en !== 1'b1 || load_value !== want_gap)
         $display("[TB] FAIL drop_arm_resume got le=%b lv=%b want le=1 lv=%b", load_en, load_value, want_gap);
      else passes++;
      // Now sitting in the settle/wait window; two more cycles reach WAIT.
      tick(1'b1, 9'd7, 1'b0);
      tick(1'b1, 9'd7, 1'b0);
      want_gap = exp_gap(m_lfsr, m_count);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 9'd0, 1'b0);
         checks++;
         if (load_en !== 1'b0 || spawn !== 1'b0)
            $display("[TB] FAIL drop_wait_quiet got le=%b sp=%b want 0 0", load_en, spawn);
         else passes++;
      end
      guard = 0;
      tick(1'b1, 9'd0, 1'b0);
      tick(1'b1, 9'd0, 1'b0);
      checks++;
      if (load_en !== 1'b1 || load_value !== want_gap || spawn !== 1'b0)
         $display("[TB] FAIL drop_wait_resume got le=%b lv=%b sp=%b want le=1 lv=%b sp=0",
                  load_en, load_value, spawn, want_gap);
      else passes++;
      // The held LFSR must also produce the predicted obstacle kind.
      while (spawn !== 1'b1 && guard < 10) begin
         tick(1'b1, 9'd0, 1'b0);
         guard++;
      end
      checks++;
      if (spawn !== 1'b1 || obstacle_type !== m_type)
         $display("[TB] FAIL drop_resume_type got sp=%b ty=%b want sp=1 ty=%b", spawn, obstacle_type, m_type);
      else passes++;
   endtask

   task automatic test_random;
      logic       en;
      logic [8:0] cnt;
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom_range(0, 15) != 0);
         cnt = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
         tick(en, cnt, 1'b0);
         checks++;
         if (load_en !== m_load_en || spawn !== m_spawn || spawn_count !== 8'(m_count) ||
             obstacle_type !== m_type)
            $display("[TB] FAIL rand_outputs i=%0d got le=%b sp=%b cnt=%0d ty=%b want le=%b sp=%b cnt=%0d ty=%b",
                     i, load_en, spawn, spawn_count, obstacle_type, m_load_en, m_spawn, m_count, m_type);
         else passes++;
         if (m_load_en) begin
            checks++;
            if (load_value !== m_load_val)
               $display("[TB] FAIL rand_gap i=%0d got %b want %b", i, load_value, m_load_val);
            else passes++;
         end
      end
   endtask

   task automatic test_difficulty;
      int guard = 0;
      int hard_loads = 0;
      tick(1'b1, 9'd0, 1'b1);
      tick(1'b1, 9'd0, 1'b1);
      while (m_total < 300 && guard < 1500) begin
         tick(1'b1, 9'd0, 1'b0);
         guard++;
         checks++;
         if (load_en !== m_load_en || spawn !== m_spawn || spawn_count !== 8'(m_count))
            $display("[TB] FAIL diff_outputs got le=%b sp=%b cnt=%0d want le=%b sp=%b cnt=%0d",
                     load_en, spawn, spawn_count, m_load_en, m_spawn, m_count);
         else passes++;
         if (m_load_en && m_count >= 128) begin
            hard_loads++;
            checks++;
            if (load_value[1] !== 1'b0 || load_value !== m_load_val)
               $display("[TB] FAIL diff_hard_gap got %b want %b", load_value, m_load_val);
            else passes++;
         end
      end
      checks++;
      if (m_total < 300) $display("[TB] FAIL diff_timeout got %0d spawns want 300", m_total);
      else passes++;
      checks++;
      if (spawn_count !== 8'd255) $display("[TB] FAIL diff_saturate got %0d want 255", spawn_count);
      else passes++;
      checks++;
      if (hard_loads < 100) $display("[TB] FAIL diff_hard_count got %0d want >=100", hard_loads);
      else passes++;
   endtask

   task automatic test_reset_mid;
      int guard = 0;
      tick(1'b1, 9'd0, 1'b1);
      while (!(m_count == 37 && spawn_due == t_edge + 1) && guard < 400) begin
         tick(1'b1, 9'd0, 1'b0);
         guard++;
      end
      checks++;
      if (spawn_count !== 8'd37 || guard >= 400)
         $display("[TB] FAIL mid_precondition got cnt=%0d guard=%0d want cnt=37", spawn_count, guard);
      else passes++;
      tick(1'b1, 9'd0, 1'b1);
      checks++;
      if ({load_en, load_value, spawn, obstacle_type, spawn_count} !== 14'd0)
         $display("[TB] FAIL mid_reset_outputs got le=%b lv=%b sp=%b ty=%b cnt=%0d want all 0",
                  load_en, load_value, spawn, obstacle_type, spawn_count);
      else passes++;
      tick(1'b1, 9'd0, 1'b0);
      tick(1'b1, 9'd0, 1'b0);
      checks++;
      if (load_en !== 1'b1 || load_value !== 2'b01)
         $display("[TB] FAIL mid_seed_gap got le=%b lv=%b want le=1 lv=01", load_en, load_value);
      else passes++;
      for (int i = 0; i < 3; i++) tick(1'b1, 9'd0, 1'b0);
      checks++;
      if (spawn !== 1'b1 || obstacle_type !== 2'b10 || spawn_count !== 8'd1)
         $display("[TB] FAIL mid_seed_type got sp=%b ty=%b cnt=%0d want sp=1 ty=10 cnt=1",
                  spawn, obstacle_type, spawn_count);
      else passes++;
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      count_in = 9'd0;
      test_reset();
      test_spawn_cycle();
      test_settle_guard();
      test_enable_drop();
      test_random();
      test_difficulty();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
